memory_access: RTL and testbench

MEM stage of the 5-stage RV32I pipeline. Consumes the EX/MEM register fields produced by the execute stage (ALU result, store data, dsize, MemRW, MemtoReg, destination register), runs a req/ack transaction on the data-memory port, and aligns and extends load data. Writes the MEM/WB register, including the final writeback value. Asserts a stall that the hazard unit folds into the pipeline-wide `keep` while a memory access is outstanding.

---
 rtl/memory_access_pkg.sv | 7 +
 rtl/memory_access_load_align.sv | 15 +
 rtl/memory_access.sv | 103 ++++++++++
 tb/tb_memory_access.sv | 136 +++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// memory_access_pkg: shared encodings for the MEM pipeline stage
package memory_access_pkg;
  localparam logic [1:0] MEMRW_NONE = 2'b00, MEMRW_LOAD = 2'b01, MEMRW_STORE = 2'b10;
  localparam logic [1:0] DSIZE_B = 2'b00, DSIZE_H = 2'b01, DSIZE_W = 2'b10;
  localparam logic [1:0] MEMTOREG_ALU = 2'b00, MEMTOREG_MEM = 2'b01, MEMTOREG_PC = 2'b10;
  typedef enum logic [1:0] {MA_IDLE = 2'b00, MA_WAIT = 2'b01, MA_HOLD = 2'b10, MA_DRAIN = 2'b11} ma_state_e;
endpackage

// File: rtl/memory_access_load_align.sv
// load_align: shifts the read word down to the addressed lane and sign/zero-extends it
module load_align
  import memory_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  dsize,
  input  logic        uns,
  output logic [31:0] ext
);
  logic [31:0] sh;
  assign sh = rdata >> {addr, 3'b000};
  assign ext = dsize == DSIZE_B ? {{24{~uns & sh[7]}}, sh[7:0]} :
               dsize == DSIZE_H ? {{16{~uns & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/memory_access.sv
// memory_access: MEM stage; req/ack data-memory transaction, load alignment and MEM/WB register
module memory_access
  import memory_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        keep,
  input  logic        nop,
  input  logic [31:0] ALU_co_pype,
  input  logic [31:0] read_data2_pype2,
  input  logic [4:0]  WReg_pype2,
  input  logic        RegWrite_pype2,
  input  logic [1:0]  MemtoReg_pype2,
  input  logic [1:0]  MemRW_pype2,
  input  logic [1:0]  dsize_pype2,
  input  logic [31:0] PCp4_pype2,
  input  logic [31:0] Instraction_pype2,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_wreg,
  output logic        wb_regwrite,
  output logic        wb_misalign
);
  ma_state_e   state_q, state_d;
  logic [31:0] buf_q, buf_d, wb_data_q, wb_data_d, ld_data;
  logic [4:0]  wb_wreg_q, wb_wreg_d;
  logic        wb_regwrite_q, wb_regwrite_d, wb_misalign_q, wb_misalign_d;
  logic [1:0]  off;
  logic        memop, mis, amemop, busy, unused_instr;
  assign off = ALU_co_pype[1:0];
  assign memop = MemRW_pype2 == MEMRW_LOAD || MemRW_pype2 == MEMRW_STORE;
  assign mis = memop && ((dsize_pype2 == DSIZE_H && off[0]) || (dsize_pype2 == DSIZE_W && off != 2'b00));
  assign amemop = memop && !mis;
  // a transaction is in flight either freshly issued from IDLE or parked in WAIT
  assign busy = state_q == MA_WAIT || (state_q == MA_IDLE && amemop);
  assign dmem_req = rst && (state_q == MA_IDLE ? amemop : state_q != MA_HOLD);
  assign mem_stall = (busy && !dmem_ack) || state_q == MA_DRAIN;
  assign dmem_we = MemRW_pype2 == MEMRW_STORE;
  assign dmem_addr = {ALU_co_pype[31:2], 2'b00};
  assign dmem_be = dsize_pype2 == DSIZE_B ? 4'b0001 << off :
                   dsize_pype2 == DSIZE_H ? 4'b0011 << off : 4'b1111;
  assign dmem_wdata = dsize_pype2 == DSIZE_B ? {4{read_data2_pype2[7:0]}} :
                      dsize_pype2 == DSIZE_H ? {2{read_data2_pype2[15:0]}} : read_data2_pype2;
  assign unused_instr = ^{Instraction_pype2[31:15], Instraction_pype2[13:0]};
  load_align u_align (
    .rdata (state_q == MA_HOLD ? buf_q : dmem_rdata),
    .addr  (off),
    .dsize (dsize_pype2),
    .uns   (Instraction_pype2[14]),
    .ext   (ld_data)
  );
  always_comb begin
    state_d = state_q;
    if (busy) state_d = dmem_ack ? (keep ? MA_HOLD : MA_IDLE) : nop ? MA_DRAIN : MA_WAIT;
    else if (state_q == MA_HOLD && !keep) state_d = MA_IDLE;
    else if (state_q == MA_DRAIN && dmem_ack) state_d = MA_IDLE;
    buf_d = busy && dmem_ack ? dmem_rdata : buf_q;
    wb_data_d = wb_data_q;
    wb_wreg_d = wb_wreg_q;
    wb_regwrite_d = wb_regwrite_q;
    wb_misalign_d = wb_misalign_q;
    if (nop) begin
      wb_data_d = '0;
      wb_wreg_d = '0;
      wb_regwrite_d = 1'b0;
      wb_misalign_d = 1'b0;
    end else if (!keep && !mem_stall) begin
      wb_data_d = MemtoReg_pype2 == MEMTOREG_MEM ? ld_data :
                  MemtoReg_pype2 == MEMTOREG_PC ? PCp4_pype2 : ALU_co_pype;
      wb_wreg_d = WReg_pype2;
      wb_regwrite_d = RegWrite_pype2 && !mis;
      wb_misalign_d = mis;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= MA_IDLE;
      buf_q <= '0;
      wb_data_q <= '0;
      wb_wreg_q <= '0;
      wb_regwrite_q <= 1'b0;
      wb_misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      wb_data_q <= wb_data_d;
      wb_wreg_q <= wb_wreg_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_misalign_q <= wb_misalign_d;
    end
  end
  assign wb_data = wb_data_q;
  assign wb_wreg = wb_wreg_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_misalign = wb_misalign_q;
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed vectors with hand-computed expectations for the MEM stage
module tb_memory_access;
  import memory_access_pkg::*;
  logic        clk = 1'b0, rst = 1'b0, keep = 1'b0, nop = 1'b0;
  logic [31:0] alu = '0, wd = '0, pcp4 = '0, instr = '0, rdata = '0;
  logic [4:0]  wreg = '0;
  logic        regwrite = 1'b0, ack = 1'b0;
  logic [1:0]  m2r = '0, memrw = '0, dsize = '0;
  logic        req, we, stall, wb_regwrite, wb_misalign;
  logic [31:0] addr, wdata, wb_data;
  logic [3:0]  be;
  logic [4:0]  wb_wreg;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  memory_access dut (
    .clk(clk), .rst(rst), .keep(keep), .nop(nop),
    .ALU_co_pype(alu), .read_data2_pype2(wd), .WReg_pype2(wreg), .RegWrite_pype2(regwrite),
    .MemtoReg_pype2(m2r), .MemRW_pype2(memrw), .dsize_pype2(dsize), .PCp4_pype2(pcp4),
    .Instraction_pype2(instr), .dmem_req(req), .dmem_we(we), .dmem_addr(addr), .dmem_be(be),
    .dmem_wdata(wdata), .dmem_rdata(rdata), .dmem_ack(ack), .mem_stall(stall),
    .wb_data(wb_data), .wb_wreg(wb_wreg), .wb_regwrite(wb_regwrite), .wb_misalign(wb_misalign)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic set_op(input logic [1:0] rw, input logic [1:0] ds, input logic [1:0] sel,
                        input logic [31:0] a, input logic [31:0] d, input logic u,
                        input logic [4:0] wr, input logic wen);
    memrw = rw; dsize = ds; m2r = sel; alu = a; wd = d;
    instr = u ? 32'h0000_4003 : 32'h0000_0003;
    wreg = wr; regwrite = wen;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    set_op(MEMRW_LOAD, DSIZE_W, MEMTOREG_MEM, 32'h40, 0, 0, 5'd9, 1);
    ack = 1'b1; rdata = 32'h1111_2222;
    for (int i = 0; i < 2; i++) begin
      #1 chk("rst_req", 32'(req), 0);
      step;
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_ctl", {wb_wreg, wb_regwrite, wb_misalign}, 0);
      chk("rst_state", 32'(dut.state_q), 32'(MA_IDLE));
    end
    rst = 1'b1;
    set_op(MEMRW_LOAD, DSIZE_B, MEMTOREG_MEM, 32'h103, 0, 0, 5'd5, 1);
    ack = 1'b1; rdata = 32'h8012_3456;
    #1 chk("lb_req", 32'(req), 1);
    chk("lb_be", 32'(be), 32'h8);
    chk("lb_addr", addr, 32'h100);
    chk("lb_stall", 32'(stall), 0);
    step;
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_ctl", {wb_wreg, wb_regwrite, wb_misalign}, {5'd5, 2'b10});
    set_op(MEMRW_LOAD, DSIZE_B, MEMTOREG_MEM, 32'h103, 0, 1, 5'd5, 1);
    step;
    chk("lbu_data", wb_data, 32'h0000_0080);
    set_op(MEMRW_STORE, DSIZE_H, MEMTOREG_ALU, 32'h202, 32'h0000_BEEF, 0, 5'd0, 0);
    ack = 1'b0; rdata = '0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("sh_req", {req, we, be}, {2'b11, 4'b1100});
      chk("sh_wdata", wdata, 32'hBEEF_BEEF);
      chk("sh_addr", addr, 32'h200);
      chk("sh_stall", 32'(stall), 1);
      step;
      chk("sh_hold_wb", wb_data, 32'h80);
    end
    ack = 1'b1;
    #1 chk("sh_ack_stall", 32'(stall), 0);
    step;
    chk("sh_regwrite", 32'(wb_regwrite), 0);
    chk("sh_wb_data", wb_data, 32'h202);
    chk("sh_state", 32'(dut.state_q), 32'(MA_IDLE));
    set_op(MEMRW_LOAD, DSIZE_W, MEMTOREG_MEM, 32'h40, 0, 0, 5'd7, 1);
    ack = 1'b0;
    #1 chk("kp_req0", 32'(req), 1);
    step;
    keep = 1'b1; ack = 1'b1; rdata = 32'hCAFE_F00D;
    #1 chk("kp_req1", {req, stall}, 32'b10);
    step;
    chk("kp_state", 32'(dut.state_q), 32'(MA_HOLD));
    chk("kp_wb_held", wb_data, 32'h202);
    for (int i = 0; i < 2; i++) begin
      ack = (i == 1); rdata = 32'hDEAD_BEEF;
      #1 chk("kp_no_reissue", {req, stall}, 0);
      step;
      chk("kp_hold", 32'(dut.state_q), 32'(MA_HOLD));
    end
    keep = 1'b0; ack = 1'b0;
    #1 chk("kp_req_end", 32'(req), 0);
    step;
    chk("kp_data", wb_data, 32'hCAFE_F00D);
    chk("kp_ctl", {wb_wreg, wb_regwrite, wb_misalign}, {5'd7, 2'b10});
    chk("kp_idle", 32'(dut.state_q), 32'(MA_IDLE));
    set_op(MEMRW_LOAD, DSIZE_W, MEMTOREG_MEM, 32'h006, 0, 0, 5'd4, 1);
    #1 chk("mis_req", {req, stall}, 0);
    step;
    chk("mis_flags", {wb_regwrite, wb_misalign}, 32'b01);
    set_op(MEMRW_NONE, DSIZE_W, MEMTOREG_ALU, 32'h1236, 0, 0, 5'd3, 1);
    #1 chk("alu_req", {req, stall}, 0);
    step;
    chk("alu_data", wb_data, 32'h1236);
    chk("alu_ctl", {wb_wreg, wb_regwrite, wb_misalign}, {5'd3, 2'b10});
    set_op(MEMRW_NONE, DSIZE_W, MEMTOREG_PC, 32'h5555, 0, 0, 5'd1, 1);
    pcp4 = 32'h1000;
    step;
    chk("pc_data", wb_data, 32'h1000);
    set_op(MEMRW_LOAD, DSIZE_W, MEMTOREG_MEM, 32'h80, 0, 0, 5'd6, 1);
    step;
    chk("nop_wait", 32'(dut.state_q), 32'(MA_WAIT));
    nop = 1'b1;
    #1 chk("nop_stall", 32'(stall), 1);
    step;
    chk("nop_wb_zero", {wb_data, wb_wreg, wb_regwrite, wb_misalign} == 0 ? 32'd1 : 32'd0, 1);
    chk("nop_drain", 32'(dut.state_q), 32'(MA_DRAIN));
    nop = 1'b0;
    #1 chk("drain_req", {req, stall}, 32'b11);
    step;
    ack = 1'b1; rdata = 32'h7777_7777;
    #1 chk("drain_ack_req", 32'(req), 1);
    step;
    chk("drain_idle", 32'(dut.state_q), 32'(MA_IDLE));
    chk("drain_no_retire", {wb_data, wb_regwrite} == 0 ? 32'd1 : 32'd0, 1);
    ack = 1'b0;
    set_op(MEMRW_NONE, DSIZE_W, MEMTOREG_ALU, 0, 0, 0, 5'd0, 0);
    step;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
